// File: rtl/route_pkg.sv
// route_pkg: shared types and default parameters for the route_ctrl sequencer.
// Optional SRAM source path is enabled by defining ROUTE_CTRL_SRAM_EN.
package route_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    localparam int NUM_WORDS_DEF = 10;
    localparam int LUT_LAT_DEF   = 2;
    localparam int ROUTE_ADDR_W  = 4;

endpackage

// File: rtl/route_ctrl_if.sv
// route_ctrl_if: control-side bus from the sequencer to the intermediate
// register bank and sigmoid LUT. sram_rd exists only with ROUTE_CTRL_SRAM_EN.
interface route_ctrl_if
    import route_pkg::*;
#(
    parameter int ADDR_W = ROUTE_ADDR_W
);
    logic              reg_load_en;
    logic              reg_load_sel;
    logic [ADDR_W-1:0] addr;
    logic              data_out_sel;
    logic              lut_req;
`ifdef ROUTE_CTRL_SRAM_EN
    logic              sram_rd;
`endif

    modport master (
        output reg_load_en,
        output reg_load_sel,
        output addr,
        output data_out_sel,
`ifdef ROUTE_CTRL_SRAM_EN
        output sram_rd,
`endif
        output lut_req
    );

    modport slave (
        input reg_load_en,
        input reg_load_sel,
        input addr,
        input data_out_sel,
`ifdef ROUTE_CTRL_SRAM_EN
        input sram_rd,
`endif
        input lut_req
    );

endinterface

// File: rtl/route_lat_cnt.sv
// route_lat_cnt: loadable down-counter that times the WAIT dwell while the
// LUT result propagates. expire is high in the last dwell cycle.
module route_lat_cnt #(
    parameter int LUT_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int CW = $clog2(LUT_LAT + 1);

    logic [CW-1:0] cnt;

    // Reload on every RD so a stale count after an abort can never leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LUT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/route_ctrl.sv
// route_ctrl: loads an M1 result block into the register bank, then walks each
// word through the sigmoid LUT and writes it back into the same slot.
// Define ROUTE_CTRL_SRAM_EN to add the SRAM source path (sram_sel/sram_rd).
module route_ctrl
    import route_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int LUT_LAT   = LUT_LAT_DEF,
    parameter int ADDR_W    = ROUTE_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
`ifdef ROUTE_CTRL_SRAM_EN
    input  logic         sram_sel,
`endif
    output logic         busy,
    output logic         done,
    route_ctrl_if.master bank
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              expire;

    logic              busy_nxt, done_nxt, lut_req_nxt;
    logic              rle_nxt, rls_nxt;
    logic [ADDR_W-1:0] addr_nxt;
`ifdef ROUTE_CTRL_SRAM_EN
    logic              sram_mode, sram_mode_nxt;
    logic              dos_nxt, sram_rd_nxt;
`endif

    route_lat_cnt #(.LUT_LAT(LUT_LAT)) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == RD),
        .expire (expire)
    );

    // Next state/index, with abort overriding everything, then decode the
    // outputs from the next state so they come straight out of flops.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
`ifdef ROUTE_CTRL_SRAM_EN
        sram_mode_nxt = sram_mode;
`endif
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (start) begin
`ifdef ROUTE_CTRL_SRAM_EN
                    sram_mode_nxt = sram_sel;
                    state_nxt     = sram_sel ? RD : LOAD;
`else
                    state_nxt = LOAD;
`endif
                end
            end
            LOAD: begin
                state_nxt = RD;
                idx_nxt   = '0;
            end
            RD:   state_nxt = WAIT;
            WAIT: if (expire) state_nxt = WR;
            WR: begin
                if (idx < LAST_IDX) begin
                    state_nxt = RD;
                    idx_nxt   = idx + ADDR_W'(1);
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
`ifdef ROUTE_CTRL_SRAM_EN
            sram_mode_nxt = 1'b0;
`endif
        end

        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = (state_nxt == DONE);
        rle_nxt     = (state_nxt == LOAD) || (state_nxt == WR);
        rls_nxt     = (state_nxt == WR);
        lut_req_nxt = (state_nxt == WAIT) && (state != WAIT);
        addr_nxt    = (state_nxt inside {RD, WAIT, WR}) ? idx_nxt : '0;
`ifdef ROUTE_CTRL_SRAM_EN
        dos_nxt     = sram_mode_nxt && (state_nxt inside {RD, WAIT});
        sram_rd_nxt = sram_mode_nxt && (state_nxt == RD);
`endif
    end

    // State, index and registered outputs; reset outranks abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            idx               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bank.reg_load_en  <= 1'b0;
            bank.reg_load_sel <= 1'b0;
            bank.addr         <= '0;
            bank.lut_req      <= 1'b0;
`ifdef ROUTE_CTRL_SRAM_EN
            sram_mode         <= 1'b0;
            bank.data_out_sel <= 1'b0;
            bank.sram_rd      <= 1'b0;
`endif
        end else begin
            state             <= state_nxt;
            idx               <= idx_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            bank.reg_load_en  <= rle_nxt;
            bank.reg_load_sel <= rls_nxt;
            bank.addr         <= addr_nxt;
            bank.lut_req      <= lut_req_nxt;
`ifdef ROUTE_CTRL_SRAM_EN
            sram_mode         <= sram_mode_nxt;
            bank.data_out_sel <= dos_nxt;
            bank.sram_rd      <= sram_rd_nxt;
`endif
        end
    end

`ifndef ROUTE_CTRL_SRAM_EN
    assign bank.data_out_sel = 1'b0;
`endif

endmodule

// File: tb/tb_route_ctrl.sv
// tb_route_ctrl: directed-vector bench for route_ctrl. Runs a default DUT
// (10 words, LUT_LAT=2) with a bank/LUT model and a small DUT (3 words,
// LUT_LAT=1). SRAM-path scenario is compiled in with ROUTE_CTRL_SRAM_EN.
module tb_route_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic startA = 1'b0, abortA = 1'b0, startB = 1'b0, abortB = 1'b0;
    logic busyA, doneA, busyB, doneB;
    logic srA, srB;
`ifdef ROUTE_CTRL_SRAM_EN
    logic sramSelA = 1'b0, sramSelB = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    route_ctrl_if #(.ADDR_W(4)) ifA ();
    route_ctrl_if #(.ADDR_W(4)) ifB ();

    route_ctrl #(.NUM_WORDS(10), .LUT_LAT(2), .ADDR_W(4)) dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startA),
        .abort    (abortA),
`ifdef ROUTE_CTRL_SRAM_EN
        .sram_sel (sramSelA),
`endif
        .busy     (busyA),
        .done     (doneA),
        .bank     (ifA)
    );

    route_ctrl #(.NUM_WORDS(3), .LUT_LAT(1), .ADDR_W(4)) dutB (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startB),
        .abort    (abortB),
`ifdef ROUTE_CTRL_SRAM_EN
        .sram_sel (sramSelB),
`endif
        .busy     (busyB),
        .done     (doneB),
        .bank     (ifB)
    );

    always #5 clk = ~clk;

`ifdef ROUTE_CTRL_SRAM_EN
    assign srA = ifA.sram_rd;
    assign srB = ifB.sram_rd;
`else
    assign srA = 1'b0;
    assign srB = 1'b0;
`endif

    // Output bundle: busy, done, lut_req, reg_load_en, reg_load_sel, addr[3:0], data_out_sel, sram_rd
    logic [10:0] actA, actB;
    assign actA = {busyA, doneA, ifA.lut_req, ifA.reg_load_en, ifA.reg_load_sel,
                   ifA.addr, ifA.data_out_sel, srA};
    assign actB = {busyB, doneB, ifB.lut_req, ifB.reg_load_en, ifB.reg_load_sel,
                   ifB.addr, ifB.data_out_sel, srB};

    // Expected bundle for cycle cyc after the edge that sampled start.
    function automatic logic [10:0] expVec(input int cyc, input int nw, input int lat, input bit sram);
        logic [10:0] v;
        int per, base, rel, k, ph;
        v    = '0;
        per  = 2 + lat;
        base = sram ? 0 : 1;
        if (!sram && cyc == 0) begin
            v[10] = 1'b1;
            v[7]  = 1'b1;
        end else if (cyc >= base && cyc < base + nw * per) begin
            rel    = cyc - base;
            k      = rel / per;
            ph     = rel % per;
            v[10]  = 1'b1;
            v[5:2] = 4'(k);
            if (ph == 0) begin
                v[1] = sram;
                v[0] = sram;
            end else if (ph <= lat) begin
                v[8] = (ph == 1);
                v[1] = sram;
            end else begin
                v[7] = 1'b1;
                v[6] = 1'b1;
            end
        end else if (cyc == base + nw * per) begin
            v[10] = 1'b1;
            v[9]  = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [15:0] lutf(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    // Register bank + LUT model driven by DUT A.
    logic [15:0] m1 [16];
    logic [15:0] regs [16];
    logic [15:0] dataOut, sigFb;

    always @(posedge clk) begin
        if (ifA.reg_load_en === 1'b1 && ifA.reg_load_sel === 1'b0) begin
            for (int i = 0; i < 16; i++) regs[i] <= m1[i];
        end else if (ifA.reg_load_en === 1'b1 && ifA.reg_load_sel === 1'b1) begin
            regs[ifA.addr] <= sigFb;
        end
        if (ifA.reg_load_en === 1'b0) dataOut <= regs[ifA.addr];
        if (ifA.lut_req === 1'b1) sigFb <= lutf(dataOut);
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        startA = 1'b1;
        startB = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (actA !== 11'd0 || actB !== 11'd0) begin
                errors++;
                $display("[TB] FAIL reset cyc=%0d gotA=%b gotB=%b want=0", c, actA, actB);
            end
        end
        rst_n  = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        @(negedge clk);
        checks++;
        if (actA !== 11'd0 || actB !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_release gotA=%b gotB=%b want=0", actA, actB);
        end
    endtask

    task automatic test_start_pulse();
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (cyc == 0) startA = 1'b0;
            checks++;
            if (actA !== expVec(cyc, 10, 2, 1'b0)) begin
                errors++;
                $display("[TB] FAIL pulse cyc=%0d got=%b want=%b", cyc, actA, expVec(cyc, 10, 2, 1'b0));
            end
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (regs[k] !== lutf(m1[k])) begin
                errors++;
                $display("[TB] FAIL bank slot=%0d got=%h want=%h", k, regs[k], lutf(m1[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] want;
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 46; cyc++) begin
            @(negedge clk);
            want = (cyc <= 42) ? expVec(cyc, 10, 2, 1'b0) : expVec(cyc - 43, 10, 2, 1'b0);
            checks++;
            if (actA !== want) begin
                errors++;
                $display("[TB] FAIL held cyc=%0d got=%b want=%b", cyc, actA, want);
            end
        end
        startA = 1'b0;
        abortA = 1'b1;
        @(negedge clk);
        abortA = 1'b0;
        checks++;
        if (actA !== 11'd0) begin
            errors++;
            $display("[TB] FAIL held_abort got=%b want=0", actA);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc <= 22; cyc++) begin
            @(negedge clk);
            if (cyc == 0) startA = 1'b0;
            checks++;
            if (actA !== expVec(cyc, 10, 2, 1'b0)) begin
                errors++;
                $display("[TB] FAIL pre_abort cyc=%0d got=%b want=%b", cyc, actA, expVec(cyc, 10, 2, 1'b0));
            end
        end
        abortA = 1'b1;
        for (int cyc = 23; cyc < 45; cyc++) begin
            @(negedge clk);
            abortA = 1'b0;
            checks++;
            if (actA !== 11'd0) begin
                errors++;
                $display("[TB] FAIL post_abort cyc=%0d got=%b want=0", cyc, actA);
            end
        end
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        checks++;
        if (actA !== expVec(0, 10, 2, 1'b0)) begin
            errors++;
            $display("[TB] FAIL restart_load got=%b want=%b", actA, expVec(0, 10, 2, 1'b0));
        end
        @(negedge clk);
        checks++;
        if (actA !== expVec(1, 10, 2, 1'b0)) begin
            errors++;
            $display("[TB] FAIL restart_rd0 got=%b want=%b", actA, expVec(1, 10, 2, 1'b0));
        end
        abortA = 1'b1;
        @(negedge clk);
        abortA = 1'b0;
        startA = 1'b1;
        abortA = 1'b1;
        @(negedge clk);
        checks++;
        if (actA !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_vs_start got=%b want=0", actA);
        end
        startA = 1'b0;
        abortA = 1'b0;
        @(negedge clk);
        checks++;
        if (actA !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_vs_start_after got=%b want=0", actA);
        end
    endtask

    task automatic test_small();
        @(negedge clk);
        startB = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (cyc == 0) startB = 1'b0;
            checks++;
            if (actB !== expVec(cyc, 3, 1, 1'b0) || ifB.addr > 4'd2) begin
                errors++;
                $display("[TB] FAIL small cyc=%0d got=%b want=%b", cyc, actB, expVec(cyc, 3, 1, 1'b0));
            end
        end
    endtask

`ifdef ROUTE_CTRL_SRAM_EN
    task automatic test_sram();
        @(negedge clk);
        startA   = 1'b1;
        sramSelA = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 44; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                startA   = 1'b0;
                sramSelA = 1'b0;
            end
            checks++;
            if (actA !== expVec(cyc, 10, 2, 1'b1)) begin
                errors++;
                $display("[TB] FAIL sram cyc=%0d got=%b want=%b", cyc, actA, expVec(cyc, 10, 2, 1'b1));
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) begin
            m1[i]   = 16'(16'h0137 + i * 16'h0211);
            regs[i] = '0;
        end
        dataOut = '0;
        sigFb   = '0;
        test_reset();
        test_start_pulse();
        test_back_to_back();
        test_abort();
        test_small();
`ifdef ROUTE_CTRL_SRAM_EN
        test_sram();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

endmodule
